// File: rtl/bp_be_dcache_pkt_encoder_pkg.sv
// Shared types for the BE -> dcache request path: memory classes, funct
// codes, dcache opcodes/subops and the packet layout macro.

`define DECLARE_BP_BE_DCACHE_PKT_S(vaddr_width_mp) \
  typedef struct packed {                          \
    bp_be_dcache_opcode_e        opcode;           \
    logic [vaddr_width_mp-1:0]   vaddr;            \
    logic [4:0]                  rd_addr;          \
  } bp_be_dcache_pkt_s

`define BP_BE_DCACHE_PKT_WIDTH(vaddr_width_mp) \
  ($bits(bp_be_dcache_opcode_e) + (vaddr_width_mp) + 5)

package bp_be_dcache_pkt_encoder_pkg;

  typedef enum logic [1:0] {
    e_bp_default_cfg = 2'd0,
    e_bp_sv48_cfg    = 2'd1
  } bp_params_e;

  localparam int dword_width_gp = 64;

  // Virtual address width implied by each processor configuration.
  function automatic int bp_vaddr_width(bp_params_e cfg);
    return (cfg == e_bp_sv48_cfg) ? 48 : 39;
  endfunction

  typedef enum logic [2:0] {
    e_mem_load   = 3'd0,
    e_mem_store  = 3'd1,
    e_mem_fload  = 3'd2,
    e_mem_fstore = 3'd3,
    e_mem_amo    = 3'd4
  } bp_be_mem_class_e;

  localparam logic [2:0] funct3_b  = 3'b000;
  localparam logic [2:0] funct3_h  = 3'b001;
  localparam logic [2:0] funct3_w  = 3'b010;
  localparam logic [2:0] funct3_d  = 3'b011;
  localparam logic [2:0] funct3_bu = 3'b100;
  localparam logic [2:0] funct3_hu = 3'b101;
  localparam logic [2:0] funct3_wu = 3'b110;

  localparam logic [4:0] amo_funct5_lr   = 5'b00010;
  localparam logic [4:0] amo_funct5_sc   = 5'b00011;
  localparam logic [4:0] amo_funct5_swap = 5'b00001;
  localparam logic [4:0] amo_funct5_add  = 5'b00000;
  localparam logic [4:0] amo_funct5_xor  = 5'b00100;
  localparam logic [4:0] amo_funct5_and  = 5'b01100;
  localparam logic [4:0] amo_funct5_or   = 5'b01000;
  localparam logic [4:0] amo_funct5_min  = 5'b10000;
  localparam logic [4:0] amo_funct5_max  = 5'b10100;
  localparam logic [4:0] amo_funct5_minu = 5'b11000;
  localparam logic [4:0] amo_funct5_maxu = 5'b11100;

  typedef enum logic [5:0] {
    e_dcache_op_lb, e_dcache_op_lh, e_dcache_op_lw, e_dcache_op_ld,
    e_dcache_op_lbu, e_dcache_op_lhu, e_dcache_op_lwu,
    e_dcache_op_sb, e_dcache_op_sh, e_dcache_op_sw, e_dcache_op_sd,
    e_dcache_op_flw, e_dcache_op_fld, e_dcache_op_fsw, e_dcache_op_fsd,
    e_dcache_op_lrw, e_dcache_op_scw, e_dcache_op_lrd, e_dcache_op_scd,
    e_dcache_op_amoswapw, e_dcache_op_amoaddw, e_dcache_op_amoxorw,
    e_dcache_op_amoandw, e_dcache_op_amoorw, e_dcache_op_amominw,
    e_dcache_op_amomaxw, e_dcache_op_amominuw, e_dcache_op_amomaxuw,
    e_dcache_op_amoswapd, e_dcache_op_amoaddd, e_dcache_op_amoxord,
    e_dcache_op_amoandd, e_dcache_op_amoord, e_dcache_op_amomind,
    e_dcache_op_amomaxd, e_dcache_op_amominud, e_dcache_op_amomaxud
  } bp_be_dcache_opcode_e;

  typedef enum logic [3:0] {
    e_dcache_subop_none, e_dcache_subop_lr, e_dcache_subop_sc,
    e_dcache_subop_amoswap, e_dcache_subop_amoadd, e_dcache_subop_amoxor,
    e_dcache_subop_amoand, e_dcache_subop_amoor, e_dcache_subop_amomin,
    e_dcache_subop_amomax, e_dcache_subop_amominu, e_dcache_subop_amomaxu
  } bp_be_dcache_subop_e;

  typedef enum logic [1:0] {
    e_size_b = 2'd0,
    e_size_h = 2'd1,
    e_size_w = 2'd2,
    e_size_d = 2'd3
  } bp_be_dcache_size_e;

  typedef struct packed {
    bp_be_mem_class_e mem_class;
    logic [2:0]       funct3;
    logic [4:0]       funct5;
  } bp_be_dcache_encode_in_s;

endpackage

// File: rtl/bp_be_dcache_opcode_encode.sv
// Combinational decode of {mem_class, funct3, funct5} into dcache opcode,
// AMO subop and access size. Illegal encodings collapse to a plain lb.
module bp_be_dcache_opcode_encode
  import bp_be_dcache_pkt_encoder_pkg::*;
  (input  bp_be_dcache_encode_in_s encode_i,
   output bp_be_dcache_opcode_e    opcode_o,
   output bp_be_dcache_subop_e     subop_o,
   output bp_be_dcache_size_e      size_o,
   output logic                    illegal_o
   );

  bp_be_dcache_opcode_e opcode_raw;
  bp_be_dcache_subop_e  subop_raw;
  bp_be_dcache_size_e   size_raw;
  logic                 illegal_raw;
  logic                 dword;

  assign dword = (encode_i.funct3 == funct3_d);

  // Per-class opcode/size lookup; anything unlisted is flagged illegal.
  always_comb begin
    opcode_raw  = e_dcache_op_lb;
    subop_raw   = e_dcache_subop_none;
    size_raw    = e_size_b;
    illegal_raw = 1'b0;
    case (encode_i.mem_class)
      e_mem_load: begin
        size_raw = bp_be_dcache_size_e'(encode_i.funct3[1:0]);
        case (encode_i.funct3)
          funct3_b:  opcode_raw = e_dcache_op_lb;
          funct3_h:  opcode_raw = e_dcache_op_lh;
          funct3_w:  opcode_raw = e_dcache_op_lw;
          funct3_d:  opcode_raw = e_dcache_op_ld;
          funct3_bu: opcode_raw = e_dcache_op_lbu;
          funct3_hu: opcode_raw = e_dcache_op_lhu;
          funct3_wu: opcode_raw = e_dcache_op_lwu;
          default:   illegal_raw = 1'b1;
        endcase
      end
      e_mem_store: begin
        size_raw = bp_be_dcache_size_e'(encode_i.funct3[1:0]);
        case (encode_i.funct3)
          funct3_b: opcode_raw = e_dcache_op_sb;
          funct3_h: opcode_raw = e_dcache_op_sh;
          funct3_w: opcode_raw = e_dcache_op_sw;
          funct3_d: opcode_raw = e_dcache_op_sd;
          default:  illegal_raw = 1'b1;
        endcase
      end
      e_mem_fload, e_mem_fstore: begin
        case (encode_i.funct3)
          funct3_w: begin
            size_raw   = e_size_w;
            opcode_raw = (encode_i.mem_class == e_mem_fload) ? e_dcache_op_flw : e_dcache_op_fsw;
          end
          funct3_d: begin
            size_raw   = e_size_d;
            opcode_raw = (encode_i.mem_class == e_mem_fload) ? e_dcache_op_fld : e_dcache_op_fsd;
          end
          default: illegal_raw = 1'b1;
        endcase
      end
      e_mem_amo: begin
        size_raw = dword ? e_size_d : e_size_w;
        if ((encode_i.funct3 != funct3_w) && (encode_i.funct3 != funct3_d))
          illegal_raw = 1'b1;
        case (encode_i.funct5)
          amo_funct5_lr: begin
            subop_raw = e_dcache_subop_lr;
            opcode_raw = dword ? e_dcache_op_lrd : e_dcache_op_lrw;
          end
          amo_funct5_sc: begin
            subop_raw = e_dcache_subop_sc;
            opcode_raw = dword ? e_dcache_op_scd : e_dcache_op_scw;
          end
          amo_funct5_swap: begin
            subop_raw = e_dcache_subop_amoswap;
            opcode_raw = dword ? e_dcache_op_amoswapd : e_dcache_op_amoswapw;
          end
          amo_funct5_add: begin
            subop_raw = e_dcache_subop_amoadd;
            opcode_raw = dword ? e_dcache_op_amoaddd : e_dcache_op_amoaddw;
          end
          amo_funct5_xor: begin
            subop_raw = e_dcache_subop_amoxor;
            opcode_raw = dword ? e_dcache_op_amoxord : e_dcache_op_amoxorw;
          end
          amo_funct5_and: begin
            subop_raw = e_dcache_subop_amoand;
            opcode_raw = dword ? e_dcache_op_amoandd : e_dcache_op_amoandw;
          end
          amo_funct5_or: begin
            subop_raw = e_dcache_subop_amoor;
            opcode_raw = dword ? e_dcache_op_amoord : e_dcache_op_amoorw;
          end
          amo_funct5_min: begin
            subop_raw = e_dcache_subop_amomin;
            opcode_raw = dword ? e_dcache_op_amomind : e_dcache_op_amominw;
          end
          amo_funct5_max: begin
            subop_raw = e_dcache_subop_amomax;
            opcode_raw = dword ? e_dcache_op_amomaxd : e_dcache_op_amomaxw;
          end
          amo_funct5_minu: begin
            subop_raw = e_dcache_subop_amominu;
            opcode_raw = dword ? e_dcache_op_amominud : e_dcache_op_amominuw;
          end
          amo_funct5_maxu: begin
            subop_raw = e_dcache_subop_amomaxu;
            opcode_raw = dword ? e_dcache_op_amomaxud : e_dcache_op_amomaxuw;
          end
          default: illegal_raw = 1'b1;
        endcase
      end
      default: illegal_raw = 1'b1;
    endcase
  end

  // Illegal entries must return nothing: plain lb, no subop, byte size.
  assign illegal_o = illegal_raw;
  assign opcode_o  = illegal_raw ? e_dcache_op_lb      : opcode_raw;
  assign subop_o   = illegal_raw ? e_dcache_subop_none : subop_raw;
  assign size_o    = illegal_raw ? e_size_b            : size_raw;

endmodule

// File: rtl/bp_be_dcache_pkt_encoder.sv
// Builds dcache request packets from decoded memory instructions and holds
// them in a 2-entry in-order buffer with ready/valid on both sides.
module bp_be_dcache_pkt_encoder
  import bp_be_dcache_pkt_encoder_pkg::*;
  #(parameter bp_params_e bp_params_p = e_bp_default_cfg
    , parameter logic [15:0] amo_support_p = '0
    , localparam int vaddr_width_p = bp_vaddr_width(bp_params_p)
    , localparam int dcache_pkt_width_lp = `BP_BE_DCACHE_PKT_WIDTH(vaddr_width_p)
    )
  (input  logic                           clk_i,
   input  logic                           reset_n_i,
   input  logic                           flush_i,
   input  logic                           v_i,
   output logic                           ready_and_o,
   input  logic [2:0]                     mem_class_i,
   input  logic [2:0]                     funct3_i,
   input  logic [4:0]                     funct5_i,
   input  logic [4:0]                     rd_addr_i,
   input  logic [dword_width_gp-1:0]      rs1_i,
   input  logic [dword_width_gp-1:0]      imm_i,
   input  logic [dword_width_gp-1:0]      data_i,
   output logic                           v_o,
   input  logic                           ready_and_i,
   output logic [dcache_pkt_width_lp-1:0] pkt_o,
   output logic [dword_width_gp-1:0]      data_o,
   output logic                           illegal_o,
   output logic                           misaligned_o,
   output logic                           uncached_o
   );

  `DECLARE_BP_BE_DCACHE_PKT_S(vaddr_width_p);

  typedef struct packed {
    bp_be_dcache_pkt_s         pkt;
    logic [dword_width_gp-1:0] data;
    logic                      illegal;
    logic                      misaligned;
    logic                      uncached;
  } entry_s;

  bp_be_dcache_encode_in_s   encode_in;
  bp_be_dcache_opcode_e      opcode;
  bp_be_dcache_subop_e       subop;
  bp_be_dcache_size_e        size;
  logic                      illegal;
  logic                      misaligned;
  logic [vaddr_width_p-1:0]  vaddr;
  entry_s                    entry_next;

  assign encode_in.mem_class = bp_be_mem_class_e'(mem_class_i);
  assign encode_in.funct3    = funct3_i;
  assign encode_in.funct5    = funct5_i;

  bp_be_dcache_opcode_encode opcode_encode
    (.encode_i  (encode_in)
     ,.opcode_o (opcode)
     ,.subop_o  (subop)
     ,.size_o   (size)
     ,.illegal_o(illegal)
     );

  // Address wraps silently at the virtual address width.
  assign vaddr = vaddr_width_p'(rs1_i + imm_i);

  // Natural alignment check on the low address bits for the access size.
  always_comb begin
    misaligned = 1'b0;
    case (size)
      e_size_h: misaligned = vaddr[0];
      e_size_w: misaligned = |vaddr[1:0];
      e_size_d: misaligned = |vaddr[2:0];
      default:  misaligned = 1'b0;
    endcase
  end

  assign entry_next.pkt.opcode  = opcode;
  assign entry_next.pkt.vaddr   = vaddr;
  assign entry_next.pkt.rd_addr = illegal ? 5'd0 : rd_addr_i;
  assign entry_next.data        = data_i;
  assign entry_next.illegal     = illegal;
  assign entry_next.misaligned  = misaligned;
  assign entry_next.uncached    = (subop != e_dcache_subop_none) & ~amo_support_p[subop];

  // Two-slot FIFO: pointers and occupancy live in flops, so ready_and_o
  // has no combinational dependence on ready_and_i.
  entry_s     slot_reg [2];
  logic [1:0] slot_we;
  logic       rd_ptr_reg, rd_ptr_next;
  logic       wr_ptr_reg, wr_ptr_next;
  logic [1:0] count_reg, count_next;
  logic       push, pop;
  entry_s     head;

  assign ready_and_o = (count_reg != 2'd2);
  assign v_o         = (count_reg != 2'd0);
  assign push        = v_i & ready_and_o & ~flush_i;
  assign pop         = v_o & ready_and_i & ~flush_i;

  // Next-state for pointers and occupancy; flush beats both push and pop.
  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (flush_i) begin
      rd_ptr_next = 1'b0;
      wr_ptr_next = 1'b0;
      count_next  = 2'd0;
    end else begin
      if (push) wr_ptr_next = ~wr_ptr_reg;
      if (pop)  rd_ptr_next = ~rd_ptr_reg;
      count_next = count_reg + {1'b0, push} - {1'b0, pop};
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      assign slot_we[gi] = push & (wr_ptr_reg == 1'(gi));
      // Capture the encoded entry into the slot being written.
      always_ff @(posedge clk_i) begin
        if (slot_we[gi]) slot_reg[gi] <= entry_next;
      end
    end
  endgenerate

  assign head         = slot_reg[rd_ptr_reg];
  assign pkt_o        = head.pkt;
  assign data_o       = head.data;
  assign illegal_o    = v_o & head.illegal;
  assign misaligned_o = v_o & head.misaligned;
  assign uncached_o   = v_o & head.uncached;

endmodule

// File: tb/tb_bp_be_dcache_pkt_encoder.sv
// Randomized + directed bench for the dcache packet encoder. Two instances
// share stimulus: one with no AMO support, one supporting only amoand.
module tb_bp_be_dcache_pkt_encoder;
  import bp_be_dcache_pkt_encoder_pkg::*;

  localparam int vaddr_w = 39;
  localparam int op_w    = $bits(bp_be_dcache_opcode_e);
  localparam int pkt_w   = op_w + vaddr_w + 5;
  localparam logic [15:0] support0 = 16'h0000;
  localparam logic [15:0] support1 = 16'h0001 << 6; // amoand subop

  typedef struct {
    bp_be_dcache_opcode_e opcode;
    logic [vaddr_w-1:0]   vaddr;
    logic [4:0]           rd;
    logic [63:0]          data;
    logic                 illegal;
    logic                 mis;
    logic                 unc0;
    logic                 unc1;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        flush_i, v_i, ready_and_i;
  logic [2:0]  mem_class_i, funct3_i;
  logic [4:0]  funct5_i, rd_addr_i;
  logic [63:0] rs1_i, imm_i, data_i;

  logic             dut_ready [2];
  logic             dut_v     [2];
  logic [pkt_w-1:0] dut_pkt   [2];
  logic [63:0]      dut_data  [2];
  logic             dut_ill   [2];
  logic             dut_mis   [2];
  logic             dut_unc   [2];

  exp_t exp_q [$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk_i = ~clk_i;

  bp_be_dcache_pkt_encoder #(.amo_support_p(support0)) dut0
    (.clk_i(clk_i), .reset_n_i(reset_n_i), .flush_i(flush_i), .v_i(v_i),
     .ready_and_o(dut_ready[0]), .mem_class_i(mem_class_i), .funct3_i(funct3_i),
     .funct5_i(funct5_i), .rd_addr_i(rd_addr_i), .rs1_i(rs1_i), .imm_i(imm_i),
     .data_i(data_i), .v_o(dut_v[0]), .ready_and_i(ready_and_i), .pkt_o(dut_pkt[0]),
     .data_o(dut_data[0]), .illegal_o(dut_ill[0]), .misaligned_o(dut_mis[0]),
     .uncached_o(dut_unc[0]));

  bp_be_dcache_pkt_encoder #(.amo_support_p(support1)) dut1
    (.clk_i(clk_i), .reset_n_i(reset_n_i), .flush_i(flush_i), .v_i(v_i),
     .ready_and_o(dut_ready[1]), .mem_class_i(mem_class_i), .funct3_i(funct3_i),
     .funct5_i(funct5_i), .rd_addr_i(rd_addr_i), .rs1_i(rs1_i), .imm_i(imm_i),
     .data_i(data_i), .v_o(dut_v[1]), .ready_and_i(ready_and_i), .pkt_o(dut_pkt[1]),
     .data_o(dut_data[1]), .illegal_o(dut_ill[1]), .misaligned_o(dut_mis[1]),
     .uncached_o(dut_unc[1]));

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [op_w-1:0] op_of(input logic [pkt_w-1:0] p);
    return p[pkt_w-1 -: op_w];
  endfunction
  function automatic logic [vaddr_w-1:0] vaddr_of(input logic [pkt_w-1:0] p);
    return p[vaddr_w+4:5];
  endfunction
  function automatic logic [4:0] rd_of(input logic [pkt_w-1:0] p);
    return p[4:0];
  endfunction

  // Reference: table lookups over the instruction set, byte-count based
  // alignment, subop membership in the support mask.
  function automatic exp_t model_encode(input logic [2:0] mc, input logic [2:0] f3,
                                        input logic [4:0] f5, input logic [4:0] rd,
                                        input logic [63:0] rs1, input logic [63:0] imm,
                                        input logic [63:0] data);
    exp_t e;
    bp_be_dcache_opcode_e load_tab [7];
    bp_be_dcache_opcode_e store_tab [4];
    logic [4:0]           amo_f5 [11];
    int                   amo_sub [11];
    bp_be_dcache_opcode_e amo_w [11];
    bp_be_dcache_opcode_e amo_d [11];
    bp_be_dcache_opcode_e op;
    logic [63:0] sum;
    logic ok;
    int nbytes, sub;
    load_tab  = '{e_dcache_op_lb, e_dcache_op_lh, e_dcache_op_lw, e_dcache_op_ld,
                  e_dcache_op_lbu, e_dcache_op_lhu, e_dcache_op_lwu};
    store_tab = '{e_dcache_op_sb, e_dcache_op_sh, e_dcache_op_sw, e_dcache_op_sd};
    amo_f5  = '{5'b00010, 5'b00011, 5'b00001, 5'b00000, 5'b00100, 5'b01100,
                5'b01000, 5'b10000, 5'b10100, 5'b11000, 5'b11100};
    amo_sub = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11};
    amo_w = '{e_dcache_op_lrw, e_dcache_op_scw, e_dcache_op_amoswapw, e_dcache_op_amoaddw,
              e_dcache_op_amoxorw, e_dcache_op_amoandw, e_dcache_op_amoorw, e_dcache_op_amominw,
              e_dcache_op_amomaxw, e_dcache_op_amominuw, e_dcache_op_amomaxuw};
    amo_d = '{e_dcache_op_lrd, e_dcache_op_scd, e_dcache_op_amoswapd, e_dcache_op_amoaddd,
              e_dcache_op_amoxord, e_dcache_op_amoandd, e_dcache_op_amoord, e_dcache_op_amomind,
              e_dcache_op_amomaxd, e_dcache_op_amominud, e_dcache_op_amomaxud};
    sum = rs1 + imm;
    e.vaddr = sum[vaddr_w-1:0];
    ok = 1'b0; nbytes = 1; sub = 0; op = e_dcache_op_lb;
    case (mc)
      3'd0: if (f3 != 3'd7) begin ok = 1'b1; op = load_tab[int'(f3)]; nbytes = 1 << int'(f3[1:0]); end
      3'd1: if (f3 < 3'd4) begin ok = 1'b1; op = store_tab[int'(f3[1:0])]; nbytes = 1 << int'(f3[1:0]); end
      3'd2: if (f3 == 3'd2) begin ok = 1'b1; op = e_dcache_op_flw; nbytes = 4; end
            else if (f3 == 3'd3) begin ok = 1'b1; op = e_dcache_op_fld; nbytes = 8; end
      3'd3: if (f3 == 3'd2) begin ok = 1'b1; op = e_dcache_op_fsw; nbytes = 4; end
            else if (f3 == 3'd3) begin ok = 1'b1; op = e_dcache_op_fsd; nbytes = 8; end
      3'd4: if (f3 == 3'd2 || f3 == 3'd3) begin
              for (int i = 0; i < 11; i++) begin
                if (f5 == amo_f5[i]) begin
                  ok = 1'b1; sub = amo_sub[i];
                  op = (f3 == 3'd3) ? amo_d[i] : amo_w[i];
                  nbytes = (f3 == 3'd3) ? 8 : 4;
                end
              end
            end
      default: ok = 1'b0;
    endcase
    e.illegal = !ok;
    e.opcode  = ok ? op : e_dcache_op_lb;
    e.rd      = ok ? rd : 5'd0;
    e.data    = data;
    e.mis     = ok && ((int'(e.vaddr[2:0]) % nbytes) != 0);
    e.unc0    = ok && (sub != 0) && !support0[sub];
    e.unc1    = ok && (sub != 0) && !support1[sub];
    return e;
  endfunction

  task automatic check_outputs();
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      check_value($sformatf("d%0d.v_o", d), 64'(dut_v[d]), 64'(exp_q.size() != 0));
      check_value($sformatf("d%0d.ready", d), 64'(dut_ready[d]), 64'(exp_q.size() < 2));
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        check_value($sformatf("d%0d.opcode", d), 64'(op_of(dut_pkt[d])), 64'(e.opcode));
        check_value($sformatf("d%0d.vaddr", d), 64'(vaddr_of(dut_pkt[d])), 64'(e.vaddr));
        check_value($sformatf("d%0d.rd", d), 64'(rd_of(dut_pkt[d])), 64'(e.rd));
        check_value($sformatf("d%0d.data", d), dut_data[d], e.data);
        check_value($sformatf("d%0d.illegal", d), 64'(dut_ill[d]), 64'(e.illegal));
        check_value($sformatf("d%0d.misaligned", d), 64'(dut_mis[d]), 64'(e.mis));
        check_value($sformatf("d%0d.uncached", d), 64'(dut_unc[d]), 64'(d == 0 ? e.unc0 : e.unc1));
      end
    end
  endtask

  // Drive one cycle of inputs, advance the queue model, then check.
  task automatic step(input logic v, input logic [2:0] mc, input logic [2:0] f3,
                      input logic [4:0] f5, input logic [4:0] rd, input logic [63:0] rs1,
                      input logic [63:0] imm, input logic [63:0] data,
                      input logic rdy, input logic fl);
    logic push, pop;
    exp_t e;
    v_i = v; mem_class_i = mc; funct3_i = f3; funct5_i = f5; rd_addr_i = rd;
    rs1_i = rs1; imm_i = imm; data_i = data; ready_and_i = rdy; flush_i = fl;
    push = v && (exp_q.size() < 2);
    pop  = (exp_q.size() > 0) && rdy;
    if (fl) begin
      if (exp_q.size() != 0) $display("flush drops %0d entries", exp_q.size());
      exp_q.delete();
    end else begin
      if (pop) begin
        e = exp_q.pop_front();
        $display("pkt op=%0d vaddr=%h rd=%0d ill=%0b mis=%0b unc=%0b/%0b",
                 e.opcode, e.vaddr, e.rd, e.illegal, e.mis, e.unc0, e.unc1);
      end
      if (push) exp_q.push_back(model_encode(mc, f3, f5, rd, rs1, imm, data));
    end
    @(posedge clk_i);
    @(negedge clk_i);
    check_outputs();
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 3'd0, 3'd0, 5'd0, 5'd0, 64'd0, 64'd0, 64'd0, rdy, 1'b0);
  endtask

  initial begin
    logic [4:0]  valid_f5 [11];
    logic        v, rdy, fl;
    logic [2:0]  mc, f3;
    logic [4:0]  f5;
    logic [63:0] imm;
    valid_f5 = '{5'b00010, 5'b00011, 5'b00001, 5'b00000, 5'b00100, 5'b01100,
                 5'b01000, 5'b10000, 5'b10100, 5'b11000, 5'b11100};
    reset_n_i = 1'b0; flush_i = 1'b0; v_i = 1'b0; ready_and_i = 1'b0;
    mem_class_i = '0; funct3_i = '0; funct5_i = '0; rd_addr_i = '0;
    rs1_i = '0; imm_i = '0; data_i = '0;
    repeat (3) @(negedge clk_i);
    for (int d = 0; d < 2; d++) begin
      check_value("reset.v_o", 64'(dut_v[d]), 64'd0);
      check_value("reset.ready", 64'(dut_ready[d]), 64'd1);
      check_value("reset.flags", {61'd0, dut_ill[d], dut_mis[d], dut_unc[d]}, 64'd0);
    end
    reset_n_i = 1'b1;

    // Load round-trip: lbu at 0x1000 + (-1).
    step(1'b1, 3'd0, 3'b100, 5'd0, 5'd5, 64'h1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h55, 1'b1, 1'b0);
    check_value("lbu.opcode", 64'(op_of(dut_pkt[0])), 64'(e_dcache_op_lbu));
    check_value("lbu.vaddr", 64'(vaddr_of(dut_pkt[0])), 64'h0FFF);
    check_value("lbu.rd", 64'(rd_of(dut_pkt[0])), 64'd5);
    check_value("lbu.misaligned", 64'(dut_mis[0]), 64'd0);

    // amoand.d: uncached without support, cached with amoand supported.
    step(1'b1, 3'd4, 3'b011, 5'b01100, 5'd7, 64'h2000, 64'd8, 64'h1234, 1'b1, 1'b0);
    check_value("amoandd.opcode", 64'(op_of(dut_pkt[0])), 64'(e_dcache_op_amoandd));
    check_value("amoandd.uncached0", 64'(dut_unc[0]), 64'd1);
    check_value("amoandd.uncached1", 64'(dut_unc[1]), 64'd0);

    // Store with funct3=101 is illegal and returns nothing.
    step(1'b1, 3'd1, 3'b101, 5'd0, 5'd9, 64'h3000, 64'd0, 64'd0, 1'b1, 1'b0);
    check_value("badstore.illegal", 64'(dut_ill[0]), 64'd1);
    check_value("badstore.rd", 64'(rd_of(dut_pkt[0])), 64'd0);

    // lw at 0x1002 is misaligned.
    step(1'b1, 3'd0, 3'b010, 5'd0, 5'd3, 64'h1000, 64'd2, 64'd0, 1'b1, 1'b0);
    check_value("lw.misaligned", 64'(dut_mis[0]), 64'd1);
    idle(1'b1);

    // Backpressure: three pushes with the dcache stalled.
    step(1'b1, 3'd0, 3'b011, 5'd0, 5'd1, 64'h100, 64'd0, 64'd0, 1'b0, 1'b0);
    check_value("bp.ready_after1", 64'(dut_ready[0]), 64'd1);
    step(1'b1, 3'd0, 3'b011, 5'd0, 5'd2, 64'h108, 64'd0, 64'd0, 1'b0, 1'b0);
    check_value("bp.ready_after2", 64'(dut_ready[0]), 64'd0);
    step(1'b1, 3'd0, 3'b011, 5'd0, 5'd3, 64'h110, 64'd0, 64'd0, 1'b0, 1'b0);
    check_value("bp.head0", 64'(rd_of(dut_pkt[0])), 64'd1);
    idle(1'b1);
    check_value("bp.head1", 64'(rd_of(dut_pkt[0])), 64'd2);
    idle(1'b1);
    check_value("bp.drained", 64'(dut_v[0]), 64'd0);

    // Flush collides with push and pop.
    step(1'b1, 3'd0, 3'b010, 5'd0, 5'd4, 64'h200, 64'd0, 64'd0, 1'b0, 1'b0);
    step(1'b1, 3'd0, 3'b010, 5'd0, 5'd6, 64'h204, 64'd0, 64'd0, 1'b1, 1'b1);
    check_value("flush.v_o", 64'(dut_v[0]), 64'd0);
    idle(1'b1);
    check_value("flush.no_emit", 64'(dut_v[0]), 64'd0);

    // Asynchronous reset with two entries buffered.
    step(1'b1, 3'd0, 3'b000, 5'd0, 5'd10, 64'h300, 64'd0, 64'd0, 1'b0, 1'b0);
    step(1'b1, 3'd0, 3'b000, 5'd0, 5'd11, 64'h301, 64'd0, 64'd0, 1'b0, 1'b0);
    v_i = 1'b0;
    reset_n_i = 1'b0;
    #1;
    check_value("rst.v_o_async0", 64'(dut_v[0]), 64'd0);
    check_value("rst.v_o_async1", 64'(dut_v[1]), 64'd0);
    exp_q.delete();
    @(posedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    idle(1'b0);
    check_value("rst.ready_after", 64'(dut_ready[0]), 64'd1);

    // Randomized traffic against the queue model.
    for (int n = 0; n < 400; n++) begin
      v   = ($urandom_range(0, 9) < 7);
      mc  = 3'($urandom_range(0, 9) > 7 ? 4 : $urandom_range(0, 7));
      f3  = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(2, 3)) : 3'($urandom_range(0, 7));
      f5  = ($urandom_range(0, 1) == 0) ? valid_f5[$urandom_range(0, 10)] : 5'($urandom_range(0, 31));
      imm = ($urandom_range(0, 1) == 0) ? 64'(signed'(32'($urandom_range(0, 15)) - 32'sd8))
                                        : {32'($urandom), 32'($urandom)};
      rdy = ($urandom_range(0, 9) < 6);
      fl  = ($urandom_range(0, 29) == 0);
      step(v, mc, f3, f5, 5'($urandom_range(0, 31)), {32'($urandom), 32'($urandom)}, imm,
           {32'($urandom), 32'($urandom)}, rdy, fl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bp_be_dcache_pkt_encoder.md
Name: bp_be_dcache_pkt_encoder

Overview:
- Encodes decoded RISC-V memory instructions (load, store, FP load/store, LR/SC/AMO) into dcache packets: opcode enum, vaddr, rd_addr, store data.
- Sits between the BE memory-pipe issue stage and the dcache request port.
- Its output is exactly what the dcache-side packet decoder consumes, so every decode field must round-trip from these inputs.
- Contains a 2-entry output buffer with ready/valid handshakes and a flush.

Parameters:
- bp_params_p, e_bp_default_cfg: processor config; supplies vaddr_width_p and dword_width_gp.
- amo_support_p, 0: bitmask indexed by dcache subop; unsupported AMOs are still encoded but flagged uncached_o.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous; empties the buffer.
- v_i  in  1  instruction valid.
- ready_and_o  out  1  encoder can accept this cycle.
- mem_class_i  in  3  bp_be_mem_class_e: load, store, fload, fstore, amo.
- funct3_i  in  3  instruction funct3.
- funct5_i  in  5  AMO funct5 (ignored unless amo).
- rd_addr_i  in  5  destination register.
- rs1_i  in  dword_width_gp  base address operand.
- imm_i  in  dword_width_gp  sign-extended offset.
- data_i  in  dword_width_gp  store/AMO operand.
- v_o  out  1  packet valid.
- ready_and_i  in  1  dcache accepts the packet.
- pkt_o  out  dcache_pkt_width_lp  {opcode, vaddr, rd_addr}.
- data_o  out  dword_width_gp  store data aligned with pkt_o.
- illegal_o  out  1  entry has an illegal encoding.
- misaligned_o  out  1  vaddr is not naturally aligned for the access size.
- uncached_o  out  1  AMO not in amo_support_p.

Behaviour:
- Reset (async on reset_n_i low): buffer empty. v_o=0, ready_and_o=1, and all flag outputs 0.
- Accept when v_i & ready_and_o. Latency is exactly 1 cycle: an entry accepted at cycle N is presented at N+1 at the earliest.
- Buffer is 2 entries, in order. ready_and_o = !full, registered (no combinational path from ready_and_i). Full throughput when the dcache accepts every cycle.
- Pop when v_o & ready_and_i.
- Simultaneous push and pop while full: rejected, because ready_and_o=0.
- Simultaneous push and pop with 1 entry: occupancy stays 1, and the new entry is shown next cycle.
- Outputs are held stable while v_o=1 and ready_and_i=0.
- flush_i: occupancy goes to 0 next cycle. A push in the same cycle as flush_i is dropped. flush_i dominates the pop.
- Address: vaddr = (rs1_i + imm_i) truncated to vaddr_width_p. Wrap-around is silent.
- Load encoding by funct3:
  - 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu.
  - 111 is illegal.
- Store encoding by funct3: 000 sb, 001 sh, 010 sw, 011 sd. Others are illegal.
- fload encoding: 010 flw, 011 fld. Others are illegal.
- fstore encoding: 010 fsw, 011 fsd. Others are illegal.
- AMO encoding:
  - funct3 010 selects w, 011 selects d; others are illegal.
  - funct5: 00010 lr, 00011 sc, 00001 swap, 00000 add, 00100 xor, 01100 and, 01000 or, 10000 min, 10100 max, 11000 minu, 11100 maxu.
  - Any other funct5 is illegal.
- Illegal entries: still enqueued so exceptions stay in order. illegal_o=1, opcode forced to e_dcache_op_lb, rd_addr forced 0, so the packet returns nothing.
- misaligned_o is set when any size-aligned low bit of vaddr is nonzero: half checks bit 0, word bits 1:0, double bits 2:0. It is never set for byte accesses.
- uncached_o = amo subop valid & !amo_support_p[subop]. LR and SC are included.
- data_o = data_i unshifted. Byte lane alignment is done in the dcache.
- All flags are registered with the entry they describe.

Decomposition:
- In bp_be_pkg:
  - bp_be_mem_class_e.
  - Funct3 and funct5 localparams (e.g. amo_funct5_lr).
  - bp_be_dcache_encode_in_s bundling the instruction fields.
- Reuse the existing bp_be_dcache_opcode_e, bp_be_dcache_subop_e and `declare_bp_be_dcache_pkt_s`. Add no new opcodes.
- One natural sub-module: bp_be_dcache_opcode_encode. It is purely combinational, mapping {mem_class, funct3, funct5} to {opcode, subop, size, illegal}.
- The buffer uses the standard 2-entry FIFO primitive.

Test Plan:
- Reset and handshake:
  - Stimulus: reset_n_i low mid-stream with 2 entries buffered.
  - Required: v_o=0 immediately, ready_and_o=1 after release.
- Load round-trip:
  - Stimulus: load funct3=100, rs1=0x1000, imm=0xFFFF_FFFF_FFFF_FFFF, rd=5.
  - Required at next cycle: opcode lbu, vaddr 0xFFF, rd 5, misaligned_o=0.
- AMO and uncached:
  - Stimulus: amo funct3=011, funct5=01100, amo_support_p=0.
  - Required: opcode amoandd, uncached_o=1.
  - Stimulus: same encoding with amo_support_p bit amoand set.
  - Required: uncached_o=0.
- Illegal and misaligned:
  - Stimulus: store funct3=101.
  - Required: illegal_o=1, rd 0.
  - Stimulus: lw with vaddr 0x1002.
  - Required: misaligned_o=1.
- Backpressure:
  - Stimulus: ready_and_i=0, push 3 instructions back-to-back.
  - Required: ready_and_o drops after the 2nd push. Then with ready_and_i=1, packets drain in order, one per cycle.
- Flush collision:
  - Stimulus: 1 entry buffered; flush_i, v_i and ready_and_i all high in the same cycle.
  - Required: next cycle v_o=0 and the new instruction is not emitted.
